// File: rtl/tdm_demux_8ch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tdm_demux_8ch_if : TDM stream in / demultiplexed frame out bundle           |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface tdm_demux_8ch_if #(
   parameter int SLOT_W = 1,
   parameter int FCNT_W = 8
);
   logic [SLOT_W-1:0]   din;
   logic                din_valid;
   logic                fsync;
   logic [8*SLOT_W-1:0] Y;
   logic                frame_valid;
   logic [7:0]          ch_strobe;
   logic [2:0]          slot;
   logic                locked;
   logic                sync_err;
   logic [FCNT_W-1:0]   frame_cnt;

   modport master (
      output din, din_valid, fsync,
      input  Y, frame_valid, ch_strobe, slot, locked, sync_err, frame_cnt
   );

   modport slave (
      input  din, din_valid, fsync,
      output Y, frame_valid, ch_strobe, slot, locked, sync_err, frame_cnt
   );
endinterface
`default_nettype wire

// File: rtl/tdm_demux_8ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tdm_demux_8ch : 1:8 TDM demultiplexer with frame alignment and sync errors  |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tdm_demux_8ch #(
   parameter int SLOT_W = 1,
   parameter int FCNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   tdm_demux_8ch_if.slave    bus
);
   localparam int c_NCH = 8;
   localparam int c_W   = c_NCH * SLOT_W;

   typedef enum logic [0:0] {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t            state_q,  state_d;
   logic [2:0]        cnt_q,    cnt_d;
   logic [c_W-1:0]    shadow_q, shadow_d;
   logic [c_W-1:0]    y_q,      y_d;
   logic              fv_q,     fv_d;
   logic [7:0]        strobe_q, strobe_d;
   logic              err_q,    err_d;
   logic [FCNT_W-1:0] fcnt_q,   fcnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_HUNT;
         cnt_q    <= '0;
         shadow_q <= '0;
         y_q      <= '0;
         fv_q     <= 1'b0;
         strobe_q <= '0;
         err_q    <= 1'b0;
         fcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         y_q      <= y_d;
         fv_q     <= fv_d;
         strobe_q <= strobe_d;
         err_q    <= err_d;
         fcnt_q   <= fcnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      y_d      = y_q;
      fcnt_d   = fcnt_q;
      fv_d     = 1'b0;
      strobe_d = '0;
      err_d    = 1'b0;

      if (bus.din_valid) begin
         case (state_q)
            ST_HUNT: begin
               if (bus.fsync) begin
                  shadow_d[SLOT_W-1:0] = bus.din;
                  strobe_d             = 8'h01;
                  cnt_d                = 3'd1;
                  state_d              = ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (cnt_q == 3'd0) begin
                  if (bus.fsync) begin
                     shadow_d[SLOT_W-1:0] = bus.din;
                     strobe_d             = 8'h01;
                     cnt_d                = 3'd1;
                  end else begin
                     // Slot 0 arrived without its sync: alignment lost.
                     err_d   = 1'b1;
                     state_d = ST_HUNT;
                  end
               end else if (bus.fsync) begin
                  // Early sync restarts the frame at this beat.
                  err_d                = 1'b1;
                  shadow_d             = '0;
                  shadow_d[SLOT_W-1:0] = bus.din;
                  strobe_d             = 8'h01;
                  cnt_d                = 3'd1;
               end else begin
                  shadow_d[int'(cnt_q)*SLOT_W +: SLOT_W] = bus.din;
                  strobe_d = 8'h01 << cnt_q;
                  cnt_d    = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     y_d    = {bus.din, shadow_q[c_W-SLOT_W-1:0]};
                     fv_d   = 1'b1;
                     fcnt_d = fcnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            default: begin
               state_d = ST_HUNT;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   assign bus.Y           = y_q;
   assign bus.frame_valid = fv_q;
   assign bus.ch_strobe   = strobe_q;
   assign bus.slot        = cnt_q;
   assign bus.locked      = (state_q == ST_LOCKED);
   assign bus.sync_err    = err_q;
   assign bus.frame_cnt   = fcnt_q;
endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_8ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tdm_demux_8ch : vector-table bench for tdm_demux_8ch                     |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_tdm_demux_8ch;
   localparam int SLOT_W = 1;
   localparam int FCNT_W = 8;

   typedef struct {
      logic       rst;
      logic       val;
      logic       fs;
      logic       din;
      logic [7:0] y;
      logic       fv;
      logic [7:0] stb;
      logic [2:0] slot;
      logic       lk;
      logic       err;
      logic [7:0] fc;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tdm_demux_8ch_if #(.SLOT_W(SLOT_W), .FCNT_W(FCNT_W)) bus ();

   tdm_demux_8ch #(.SLOT_W(SLOT_W), .FCNT_W(FCNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   vec_t tbl[$];
   vec_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic add(input logic r, input logic v, input logic f, input logic d,
                      input logic [7:0] y, input logic fv, input logic [7:0] stb,
                      input logic [2:0] sl, input logic lk, input logic err,
                      input logic [7:0] fc);
      vec_t e;
      e.rst = r;  e.val = v;  e.fs = f;   e.din = d;
      e.y   = y;  e.fv  = fv; e.stb = stb; e.slot = sl;
      e.lk  = lk; e.err = err; e.fc = fc;
      tbl.push_back(e);
   endtask

   // One aligned frame; slot k carries data[k].
   task automatic add_frame(input logic [7:0] data, input logic [7:0] y_prev,
                            input logic [7:0] fc_prev);
      for (int k = 0; k < 8; k++) begin
         add(1'b0, 1'b1, (k == 0), data[k],
             (k == 7) ? data : y_prev, (k == 7), 8'(1 << k), 3'(k + 1),
             1'b1, 1'b0, (k == 7) ? fc_prev + 8'd1 : fc_prev);
      end
   endtask

   task automatic check(input string tag, input int idx);
      vec_t x;
      logic [28:0] act, exp;
      x   = sb.pop_front();
      act = {bus.Y, bus.frame_valid, bus.ch_strobe, bus.slot, bus.locked,
             bus.sync_err, bus.frame_cnt};
      exp = {x.y, x.fv, x.stb, x.slot, x.lk, x.err, x.fc};
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got Y=%h fv=%b stb=%h slot=%0d lk=%b err=%b fcnt=%0d; expected Y=%h fv=%b stb=%h slot=%0d lk=%b err=%b fcnt=%0d",
                    tag, idx, bus.Y, bus.frame_valid, bus.ch_strobe, bus.slot,
                    bus.locked, bus.sync_err, bus.frame_cnt,
                    x.y, x.fv, x.stb, x.slot, x.lk, x.err, x.fc);
   endtask

   task automatic step(input vec_t e, input string tag, input int idx);
      rst           = e.rst;
      bus.din_valid = e.val;
      bus.fsync     = e.fs;
      bus.din       = e.din;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check(tag, idx);
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < tbl.size(); i++) step(tbl[i], tag, i);
      tbl.delete();
   endtask

   initial begin
      rst = 1'b1; bus.din_valid = 1'b0; bus.fsync = 1'b0; bus.din = 1'b0;
      #2;

      // Reset and frame 1,0,1,1,0,0,1,0 with a 3-cycle gap after slot 3.
      add(1,0,0,0, 8'h00,0,8'h00,0,0,0,0);
      add(0,1,1,1, 8'h00,0,8'h01,1,1,0,0);
      add(0,1,0,0, 8'h00,0,8'h02,2,1,0,0);
      add(0,1,0,1, 8'h00,0,8'h04,3,1,0,0);
      add(0,1,0,1, 8'h00,0,8'h08,4,1,0,0);
      add(0,0,0,0, 8'h00,0,8'h00,4,1,0,0);
      add(0,0,1,1, 8'h00,0,8'h00,4,1,0,0);
      add(0,0,0,1, 8'h00,0,8'h00,4,1,0,0);
      add(0,1,0,0, 8'h00,0,8'h10,5,1,0,0);
      add(0,1,0,0, 8'h00,0,8'h20,6,1,0,0);
      add(0,1,0,1, 8'h00,0,8'h40,7,1,0,0);
      add(0,1,0,0, 8'h4D,1,8'h80,0,1,0,1);
      add(0,0,0,0, 8'h4D,0,8'h00,0,1,0,1);
      // Early sync after 3 beats: restart at slot 0, then slots 1..7 = 0,..,0,1.
      add(0,1,1,0, 8'h4D,0,8'h01,1,1,0,1);
      add(0,1,0,1, 8'h4D,0,8'h02,2,1,0,1);
      add(0,1,0,1, 8'h4D,0,8'h04,3,1,0,1);
      add(0,1,1,1, 8'h4D,0,8'h01,1,1,1,1);
      for (int k = 1; k < 7; k++) add(0,1,0,0, 8'h4D,0,8'(1 << k),3'(k + 1),1,0,1);
      add(0,1,0,1, 8'h81,1,8'h80,0,1,0,2);
      // Missing sync drops lock; five unsynced beats ignored; relock.
      add(0,1,0,1, 8'h81,0,8'h00,0,0,1,2);
      for (int k = 0; k < 5; k++) add(0,1,0,1, 8'h81,0,8'h00,0,0,0,2);
      add(0,1,1,0, 8'h81,0,8'h01,1,1,0,2);
      for (int k = 1; k < 7; k++) add(0,1,0,1, 8'h81,0,8'(1 << k),3'(k + 1),1,0,2);
      add(0,1,0,1, 8'hFE,1,8'h80,0,1,0,3);
      // Back-to-back frames.
      add_frame(8'hFF, 8'hFE, 8'd3);
      add_frame(8'h00, 8'hFF, 8'd4);
      // Reset during slot 5, then unsynced beats ignored.
      for (int k = 0; k < 5; k++) add(0,1,(k == 0),1, 8'h00,0,8'(1 << k),3'(k + 1),1,0,5);
      add(1,1,0,1, 8'h00,0,8'h00,0,0,0,0);
      for (int k = 0; k < 3; k++) add(0,1,0,1, 8'h00,0,8'h00,0,0,0,0);
      add(0,1,1,1, 8'h00,0,8'h01,1,1,0,0);
      run_table("main");

      // Frame counter wrap: 256 frames after reset bring the count back to 0.
      add(1,0,0,0, 8'h00,0,8'h00,0,0,0,0);
      for (int f = 0; f < 256; f++) add_frame(8'h00, 8'h00, 8'(f));
      add(0,0,0,0, 8'h00,0,8'h00,0,1,0,0);
      run_table("wrap");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/tdm_demux_8ch.md
Name: tdm_demux_8ch

Overview:
Receive-side counterpart of the 8:1 channel multiplexer. Accepts a time-division-multiplexed stream with one slot per beat and a frame sync on slot 0, then routes each slot to its channel. Tracks the slot index internally, so it is the 1:8 demultiplexer with frame alignment. Presents the eight channels as a registered parallel word once per complete frame, with per-slot strobes and sync-error reporting.

Parameters:
SLOT_W, 1, bits carried per slot (channel width)
FCNT_W, 8, width of wrapping good-frame counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
din  input  SLOT_W  slot data
din_valid  input  1  din/fsync valid this cycle; idle cycles allowed anywhere
fsync  input  1  marks slot 0 of a frame; sampled only when din_valid=1
Y  output  8*SLOT_W  last complete frame; channel k at Y[k*SLOT_W +: SLOT_W]
frame_valid  output  1  1-cycle pulse: Y updated
ch_strobe  output  8  one-hot 1-cycle pulse: slot k accepted
slot  output  3  index the next valid beat is expected to carry
locked  output  1  1 in LOCKED state
sync_err  output  1  1-cycle pulse on alignment error
frame_cnt  output  FCNT_W  count of completed frames, wraps

Behaviour:
- Reset (rst=1 at posedge): state=HUNT, internal slot counter=0, shadow register=0, Y=0, frame_valid=0, ch_strobe=0, slot=0, locked=0, sync_err=0, frame_cnt=0. Reset overrides all inputs. Reset mid-frame discards the partial frame.
- All outputs are registered. Every response appears the cycle after the accepting edge. Cycles with din_valid=0 change nothing except clearing the pulses.
- HUNT: beats with fsync=0 are dropped with no strobe and no error. A beat with fsync=1 writes shadow[0]=din, pulses ch_strobe[0], sets cnt=1, and moves to LOCKED.
- LOCKED, valid beat, cnt=k≠0, fsync=0:
  - shadow[k]=din, ch_strobe[k] pulses, cnt=k+1 (mod 8).
  - If k=7: Y={din, shadow[6:0]} (slot 7 written directly), frame_valid pulses, frame_cnt+1 (wraps at 2^FCNT_W), cnt=0.
- LOCKED, cnt=0, fsync=1: normal slot-0 write with ch_strobe[0], cnt=1.
- LOCKED, cnt≠0, fsync=1 (early sync):
  - sync_err pulses and the partial frame is discarded (shadow cleared).
  - The beat is taken as slot 0 (shadow[0]=din, ch_strobe[0]), cnt=1, state stays LOCKED.
  - Y and frame_cnt are unchanged.
- LOCKED, cnt=0, fsync=0 (missing sync): sync_err pulses, the beat is dropped, state goes to HUNT, and Y is held.
- slot output = cnt (0 in HUNT). locked = (state==LOCKED).
- Y holds its value between frames. It never shows a partial frame.
- Back-to-back frames with no idle cycles are supported: frame_valid can pulse every 8 valid beats.

Test Plan:
- Reset, then fsync+8 valid beats, SLOT_W=1, din=1,0,1,1,0,0,1,0 (slots 0..7) → ch_strobe walks 0x01..0x80, after the 8th beat Y=8'b01001101 and frame_valid pulses once, frame_cnt=1, locked=1.
- Same frame with din_valid dropped for 3 cycles between slots 3 and 4 → identical Y, no strobes during the gap, slot holds at 4.
- First frame complete (Y=0x4D), then 3 beats of a second frame, then fsync with din=1 → sync_err pulses, Y stays 0x4D, slot=1. A full frame completing from that point updates Y normally.
- After a complete frame, a valid beat with fsync=0 → sync_err, locked=0, Y held. The next 5 beats without fsync produce no strobe. The fsync beat after them relocks.
- Two back-to-back frames 0xFF then 0x00 → frame_valid pulses exactly 8 cycles apart, Y=0xFF then 0x00, frame_cnt=2.
- Assert rst during slot 5 of a frame → all outputs 0 the next cycle, state HUNT. Subsequent beats without fsync are ignored.
